// File: rtl/sysinfo_regs.sv
// System-information Avalon-MM slave: build constants, scratch register,
// 64-bit uptime with tear-free high-word snapshot, and a seconds counter.
module sysinfo_regs #(
  parameter logic [31:0] SYSTEM_ID = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP = 32'd0,
  parameter logic [31:0] VERSION   = 32'h0001_0000,
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned ADDR_W    = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

  localparam logic [31:0] CLK_HZ_W = 32'(CLK_HZ);
  localparam logic [31:0] PS_LAST  = 32'(CLK_HZ - 1);

  logic [31:0] scratch_q,   scratch_d;
  logic [63:0] uptime_q,    uptime_d;
  logic [31:0] hi_snap_q,   hi_snap_d;
  logic [31:0] prescale_q,  prescale_d;
  logic [31:0] seconds_q,   seconds_d;
  logic [31:0] readdata_q,  readdata_d;
  logic        rdvalid_q,   rdvalid_d;

  logic        in_map;
  logic [2:0]  word;
  logic [31:0] rd_word;

  // Addresses at or above 8 must not alias onto the 8-word map.
  assign in_map = ((address >> 3) == '0);
  assign word   = address[2:0];

  always_comb begin
    rd_word = '0;
    if (in_map) begin
      case (word)
        3'd0:    rd_word = SYSTEM_ID;
        3'd1:    rd_word = TIMESTAMP;
        3'd2:    rd_word = VERSION;
        3'd3:    rd_word = scratch_q;
        3'd4:    rd_word = uptime_q[31:0];
        3'd5:    rd_word = hi_snap_q;
        3'd6:    rd_word = seconds_q;
        default: rd_word = CLK_HZ_W;
      endcase
    end
  end

  always_comb begin
    scratch_d  = scratch_q;
    hi_snap_d  = hi_snap_q;
    uptime_d   = uptime_q + 64'd1;
    prescale_d = prescale_q + 32'd1;
    seconds_d  = seconds_q;
    readdata_d = readdata_q;
    rdvalid_d  = read;

    if (prescale_q == PS_LAST) begin
      prescale_d = '0;
      seconds_d  = seconds_q + 32'd1;
    end

    if (write && in_map && (word == 3'd3)) begin
      for (int unsigned i = 0; i < 4; i++) begin
        if (byteenable[i]) scratch_d[8*i +: 8] = writedata[8*i +: 8];
      end
    end

    if (read) begin
      readdata_d = rd_word;
      // Latch the high half alongside the low-word read so LO/HI pairs stay coherent.
      if (in_map && (word == 3'd4)) hi_snap_d = uptime_q[63:32];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q  <= '0;
      uptime_q   <= '0;
      hi_snap_q  <= '0;
      prescale_q <= '0;
      seconds_q  <= '0;
      readdata_q <= '0;
      rdvalid_q  <= 1'b0;
    end else begin
      scratch_q  <= scratch_d;
      uptime_q   <= uptime_d;
      hi_snap_q  <= hi_snap_d;
      prescale_q <= prescale_d;
      seconds_q  <= seconds_d;
      readdata_q <= readdata_d;
      rdvalid_q  <= rdvalid_d;
    end
  end

  assign readdata      = readdata_q;
  assign readdatavalid = rdvalid_q;

endmodule

// File: tb/tb_sysinfo_regs.sv
// Directed scoreboard bench for sysinfo_regs: reads push expectations,
// a negedge monitor pops and compares on each readdatavalid.
module tb_sysinfo_regs;

  logic        clock;
  logic        reset_n;
  logic [3:0]  address;
  logic        read;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;
  logic        readdatavalid;

  int          ncmp = 0;
  int          nfail = 0;
  int          cyc = 0;
  logic [31:0] expq[$];
  string       tagq[$];

  sysinfo_regs #(
    .SYSTEM_ID(32'hCAFE_0001),
    .TIMESTAMP(32'h6500_0000),
    .VERSION  (32'h0002_0003),
    .CLK_HZ   (10),
    .ADDR_W   (4)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Edges elapsed since reset release; the next sampling edge is cyc+1.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clock) begin
    if (readdatavalid === 1'b1) begin
      if (expq.size() == 0) chk("spurious_valid", {31'b0, readdatavalid}, 32'd0);
      else                  chk(tagq.pop_front(), readdata, expq.pop_front());
    end
  end

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string tag);
    address = a;
    read    = 1'b1;
    expq.push_back(exp);
    tagq.push_back(tag);
    @(negedge clock);
    read = 1'b0;
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    @(negedge clock);
    write = 1'b0;
  endtask

  task automatic read_at_edge(input int edge_n, input logic [3:0] a, input logic [31:0] exp,
                              input string tag);
    while (cyc + 1 < edge_n) @(negedge clock);
    do_read(a, exp, tag);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e;
    reset_n = 1'b0; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0;
    repeat (2) @(negedge clock);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_valid", {31'b0, readdatavalid}, 32'd0);
    reset_n = 1'b1;

    // T1: build constants back-to-back, plus reset values of the live registers
    do_read(4'd0, 32'hCAFE_0001, "t1_id");
    do_read(4'd1, 32'h6500_0000, "t1_timestamp");
    do_read(4'd2, 32'h0002_0003, "t1_version");
    do_read(4'd7, 32'd10,        "t1_clk_hz");
    do_read(4'd3, 32'd0,         "t1_scratch_rst");
    do_read(4'd5, 32'd0,         "t1_hi_rst");
    do_read(4'd4, 32'(cyc),      "t1_uptime_lo");
    do_read(4'd5, 32'd0,         "t1_hi_snap");
    do_read(4'd6, 32'(cyc / 10), "t1_seconds");

    // T5: simultaneous read and write of scratch returns the old value
    address = 4'd3; writedata = 32'h5; byteenable = 4'hF;
    read = 1'b1; write = 1'b1;
    expq.push_back(32'd0); tagq.push_back("t5_rw_old");
    @(negedge clock);
    read = 1'b0; write = 1'b0;
    do_read(4'd3, 32'h5, "t5_rw_new");

    // T2: byte-enabled scratch writes, read-only and out-of-map writes ignored
    do_write(4'd3, 32'hDEAD_BEEF, 4'hF);
    do_write(4'd3, 32'h0000_1122, 4'b0011);
    do_read(4'd3, 32'hDEAD_1122, "t2_scratch_be");
    do_write(4'd0, 32'h1234_5678, 4'hF);
    do_read(4'd0, 32'hCAFE_0001, "t2_id_ro");
    do_write(4'd11, 32'hFFFF_FFFF, 4'hF);
    do_read(4'd3, 32'hDEAD_1122, "t2_no_alias_wr");
    do_read(4'd11, 32'd0, "t2_oob_11");
    do_read(4'd9,  32'd0, "t2_oob_9");
    do_read(4'd6, 32'(cyc / 10), "t2_seconds");

    // T4: seconds ticks exactly on every tenth edge
    read_at_edge(30, 4'd6, 32'd2, "t4_sec_e30");
    read_at_edge(31, 4'd6, 32'd3, "t4_sec_e31");
    read_at_edge(36, 4'd6, 32'd3, "t4_sec_e36");
    read_at_edge(40, 4'd6, 32'd3, "t4_sec_e40");
    read_at_edge(41, 4'd6, 32'd4, "t4_sec_e41");

    // T3: coherent LO/HI across a carry out of the low word
    e = cyc + 1;
    force dut.uptime_q = 64'h0000_0001_FFFF_FFFE;
    address = 4'd4; read = 1'b1;
    expq.push_back(32'hFFFF_FFFE); tagq.push_back("t3_lo");
    #1 release dut.uptime_q;
    @(negedge clock);
    read = 1'b0;
    read_at_edge(e + 10, 4'd5, 32'h0000_0001, "t3_hi_snap");
    read_at_edge(e + 12, 4'd4, 32'h0000_000A, "t3_lo_after_carry");
    do_read(4'd5, 32'h0000_0002, "t3_hi_after_carry");

    // T6: reset lands while a read response is in flight
    do_write(4'd3, 32'h1234_5678, 4'hF);
    address = 4'd3; read = 1'b1;
    @(posedge clock);
    #1 reset_n = 1'b0;
    read = 1'b0;
    @(negedge clock);
    chk("t6_valid_dropped", {31'b0, readdatavalid}, 32'd0);
    chk("t6_readdata_rst", readdata, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    do_read(4'd3, 32'd0, "t6_scratch");
    do_read(4'd5, 32'd0, "t6_hi_snap");
    do_read(4'd4, 32'(cyc), "t6_uptime_lo");
    read_at_edge(10, 4'd6, 32'd0, "t6_sec_e10");
    read_at_edge(11, 4'd6, 32'd1, "t6_sec_e11");

    repeat (3) @(negedge clock);
    chk("sb_drained", 32'(expq.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
